// File: rtl/mccpu_ctrl_hs.sv
// mccpu_ctrl_hs: RV32I multicycle control FSM driving datapath strobes and the req/ready memory handshake (opcode/funct3/flags in; mem_req/we, addr_sel, ir/reg/pc write, wd_sel, npc_sel, retire, sticky illegal/bus_err, state_o out)
module mccpu_ctrl_hs #(
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 4,
  parameter bit ENABLE_JALR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wd_sel,
  output logic       pc_write,
  output logic [1:0] npc_sel,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic legal, taken, br_bad, wd_fire;
  assign is_r     = opcode == 7'b0110011;
  assign is_i     = opcode == 7'b0010011;
  assign is_ld    = opcode == 7'b0000011;
  assign is_st    = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | (is_jalr & ENABLE_JALR) | is_lui | is_auipc;
  assign taken    = funct3[2] ? ((funct3[1] ? ltu : lt) ^ funct3[0]) : (zero ^ funct3[0]);
  assign br_bad   = funct3[2:1] == 2'b01;
  assign wd_fire  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !mem_ready;
  assign illegal  = illegal_q & ~rst;
  assign bus_err  = bus_err_q & ~rst;
  assign state_o  = rst ? 3'd0 : state_q;
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wd_sel        = 2'd0;
    pc_write      = 1'b0;
    npc_sel       = 2'd0;
    instr_retired = 1'b0;
    if (!rst)
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = DECODE;
          end else if (wd_fire) begin
            bus_err_d = 1'b1;
            state_d   = TRAP;
          end
        end
        DECODE: begin
          state_d   = legal ? EXEC : TRAP;
          illegal_d = illegal_q | ~legal;
        end
        EXEC:
          if (is_br) begin
            if (br_bad) begin
              illegal_d = 1'b1;
              state_d   = TRAP;
            end else begin
              pc_write      = 1'b1;
              npc_sel       = taken ? 2'd1 : 2'd0;
              instr_retired = 1'b1;
              state_d       = FETCH;
            end
          end else if (is_jal | is_jalr) begin
            reg_write     = 1'b1;
            wd_sel        = 2'd2;
            pc_write      = 1'b1;
            npc_sel       = is_jal ? 2'd2 : 2'd3;
            instr_retired = 1'b1;
            state_d       = FETCH;
          end else
            state_d = (is_ld | is_st) ? MEM : WB;
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_st;
          if (mem_ready) begin
            pc_write      = is_st;
            instr_retired = is_st;
            state_d       = is_st ? FETCH : WB;
          end else if (wd_fire) begin
            bus_err_d = 1'b1;
            state_d   = TRAP;
          end
        end
        WB: begin
          reg_write     = 1'b1;
          wd_sel        = is_ld ? 2'd1 : 2'd0;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          state_d       = FETCH;
        end
        TRAP: state_d = TRAP;
        default: state_d = TRAP;
      endcase
    cnt_d = (state_d != state_q) ? '0 : (mem_req && !mem_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
endmodule

// File: tb/tb_mccpu_ctrl_hs.sv
// tb_mccpu_ctrl_hs: randomized instruction-level bench comparing both controller variants against a per-instruction cycle trace model
module tb_mccpu_ctrl_hs;
  localparam int TO = 15;
  typedef struct packed {
    logic        rdy;
    logic [15:0] v;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic [15:0] o0, o1;
  rec_t q[$];
  int errs = 0, checks = 0, sel = 0, n = 0;
  bit trapped;
  always #5 clk = ~clk;
  mccpu_ctrl_hs #(.TIMEOUT(TO), .CNT_W(4), .ENABLE_JALR(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .state_o(o0[15:13]), .mem_req(o0[12]), .mem_we(o0[11]),
    .addr_sel(o0[10]), .ir_write(o0[9]), .reg_write(o0[8]), .wd_sel(o0[7:6]),
    .pc_write(o0[5]), .npc_sel(o0[4:3]), .instr_retired(o0[2]), .illegal(o0[1]), .bus_err(o0[0])
  );
  mccpu_ctrl_hs #(.TIMEOUT(TO), .CNT_W(4), .ENABLE_JALR(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .state_o(o1[15:13]), .mem_req(o1[12]), .mem_we(o1[11]),
    .addr_sel(o1[10]), .ir_write(o1[9]), .reg_write(o1[8]), .wd_sel(o1[7:6]),
    .pc_write(o1[5]), .npc_sel(o1[4:3]), .instr_retired(o1[2]), .illegal(o1[1]), .bus_err(o1[0])
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got st/req/we/as/irw/rw/wd/pcw/npc/ret/ill/be=%b expected %b", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] v(input logic [2:0] st, input logic req, we, as, irw, rw,
                                    input logic [1:0] wd, input logic pcw, input logic [1:0] npc, input logic ret);
    return {st, req, we, as, irw, rw, wd, pcw, npc, ret, 2'b00};
  endfunction
  task automatic push(input logic r, input logic [15:0] x);
    q.push_back({r, x});
  endtask
  task automatic trap(input logic ill, input logic be);
    repeat (3) push(1'($urandom), v(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0) | {14'd0, ill, be});
    trapped = 1'b1;
  endtask
  task automatic mem_phase(input logic m, input logic st, input int w, output bit ok);
    logic [2:0] s;
    s  = m ? 3'd3 : 3'd0;
    ok = 1'b1;
    for (int i = 0; i <= w; i++)
      if (i == w)
        push(1'b1, v(s, 1'b1, m & st, m, ~m, 1'b0, 2'd0, m & st, 2'd0, m & st));
      else begin
        push(1'b0, v(s, 1'b1, m & st, m, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        if (i == TO) begin
          ok = 1'b0;
          break;
        end
      end
  endtask
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z, l, lu, input int wf, wm, input bit en);
    int c;
    bit ok;
    logic tk;
    logic [15:0] idle;
    idle = v(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    c = (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 || op == 7'b0010111) ? 0 :
        op == 7'b0000011 ? 1 : op == 7'b0100011 ? 2 : op == 7'b1100011 ? 3 :
        op == 7'b1101111 ? 4 : (op == 7'b1100111 && en) ? 5 : 6;
    trapped = 1'b0;
    mem_phase(1'b0, 1'b0, wf, ok);
    if (!ok) begin
      trap(1'b0, 1'b1);
      return;
    end
    push(1'($urandom), v(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
    if (c == 6) begin
      trap(1'b1, 1'b0);
      return;
    end
    case (c)
      0: begin
        push(1'($urandom), idle);
        push(1'($urandom), v(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1));
      end
      1, 2: begin
        push(1'($urandom), idle);
        mem_phase(1'b1, c == 2, wm, ok);
        if (!ok) trap(1'b0, 1'b1);
        else if (c == 1) push(1'($urandom), v(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1));
      end
      3: begin
        case (f3)
          3'd0: tk = z;
          3'd1: tk = !z;
          3'd4: tk = l;
          3'd5: tk = !l;
          3'd6: tk = lu;
          default: tk = !lu;
        endcase
        if (f3 == 3'd2 || f3 == 3'd3) begin
          push(1'($urandom), idle);
          trap(1'b1, 1'b0);
        end else
          push(1'($urandom), v(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, {1'b0, tk}, 1'b1));
      end
      default: push(1'($urandom), v(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, c == 4 ? 2'd2 : 2'd3, 1'b1));
    endcase
  endtask
  task automatic run(input int lim);
    rec_t r;
    for (int k = 0; k < lim && q.size() > 0; k++) begin
      r = q.pop_front();
      mem_ready = r.rdy;
      @(negedge clk);
      check($sformatf("i%0d c%0d dut%0d", n, k, sel), sel ? o1 : o0, r.v);
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    @(negedge clk);
    check($sformatf("rst%0d", n), sel ? o1 : o0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z, l, lu, input int wf, wm);
    opcode = op;
    funct3 = f3;
    zero = z;
    lt = l;
    ltu = lu;
    build(op, f3, z, l, lu, wf, wm, sel == 0);
    run(1000);
    if (trapped) do_reset();
    n++;
  endtask
  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 31));
    return r == 0 ? TO + 3 : r == 1 ? TO : r % 4;
  endfunction
  logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h00};
  initial begin
    do_reset();
    instr(7'h13, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    instr(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
    instr(7'h63, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    instr(7'h63, 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);
    instr(7'h6F, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    instr(7'h67, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    instr(7'h13, 3'd0, 1'b0, 1'b0, 1'b0, TO + 5, 0);
    instr(7'h13, 3'd0, 1'b0, 1'b0, 1'b0, TO, 0);
    instr(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 1, TO);
    instr(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 0, TO + 1);
    instr(7'h63, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0);
    sel = 1;
    do_reset();
    instr(7'h6F, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    instr(7'h67, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 60; i++)
      instr(ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rand_wait(), rand_wait());
    sel = 0;
    do_reset();
    for (int i = 0; i < 250; i++)
      instr(ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rand_wait(), rand_wait());
    opcode = 7'h23;
    funct3 = 3'd2;
    build(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 0, 6, 1'b1);
    run(5);
    do_reset();
    instr(7'h33, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
